// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding requests to a word-addressed data memory, with byte/halfword stores done as read-modify-write.
// Define LSU_RANGE_CHECK_EN to reject addresses at or beyond 4*MEM_WORDS bytes.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        range_err;
    logic        req_err;
    logic        rd_en;
    logic        wr_en;

    if (MEM_WORDS == 0 || MEM_WORDS > 32'h4000_0000) begin : g_depth_check
        $error("load_store_unit: MEM_WORDS must be in 1..2^30");
    end

`ifdef LSU_RANGE_CHECK_EN
    assign range_err = {2'b00, req_addr} >= (34'(MEM_WORDS) << 2);
`else
    assign range_err = 1'b0;
`endif

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] ofs,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{ofs, 3'b000} +: 8];
        h = ofs[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h000000, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0000, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [2:0] f3, input logic [1:0] ofs,
                                                input logic [31:0] word, input logic [31:0] wd);
        logic [31:0] m;
        m = word;
        if (f3[1:0] == 2'b00) begin
            m[{ofs, 3'b000} +: 8] = wd[7:0];
        end else if (ofs[1]) begin
            m[31:16] = wd[15:0];
        end else begin
            m[15:0] = wd[15:0];
        end
        return m;
    endfunction

    always_comb begin
        req_err = 1'b1;
        case (req_funct3)
            3'b000:         req_err = 1'b0;
            3'b001:         req_err = req_addr[0];
            3'b010:         req_err = (req_addr[1:0] != 2'b00);
            3'b100:         req_err = req_we;
            3'b101:         req_err = req_we || req_addr[0];
            default:        req_err = 1'b1;
        endcase
        req_err = req_err || range_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            word_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = req_err;
                    rdata_d  = '0;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (!req_we) begin
                        state_d = S_LOAD;
                    end else if (req_funct3 == 3'b010) begin
                        state_d = S_STORE;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                mem_addr = {addr_q[31:2], 2'b00};
                rd_en    = 1'b1;
                rdata_d  = extend_load(funct3_q, addr_q[1:0], mem_rdata);
                state_d  = S_RESP;
            end
            S_STORE: begin
                mem_addr  = {addr_q[31:2], 2'b00};
                wr_en     = 1'b1;
                mem_wdata = wdata_q;
                state_d   = S_RESP;
            end
            S_RMW_RD: begin
                mem_addr = {addr_q[31:2], 2'b00};
                rd_en    = 1'b1;
                word_d   = mem_rdata;
                state_d  = S_RMW_WR;
            end
            S_RMW_WR: begin
                mem_addr  = {addr_q[31:2], 2'b00};
                wr_en     = 1'b1;
                mem_wdata = merge_store(funct3_q, addr_q[1:0], word_q, wdata_q);
                state_d   = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = rdata_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are killed combinationally so a reset cycle can never commit a write.
        mem_read  = rd_en && !reset;
        mem_write = wr_en && !reset;
    end

    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural data memory and reference memory model.
module tb_load_store_unit;

    localparam int unsigned MW = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(MW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    logic [31:0] mem [MW];
    logic        clr_mem;
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < int'(MW); i++) mem[i] <= '0;
        end else if (mem_write) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int unsigned lat;
        int unsigned nrd;
        int unsigned nwr;
        logic [31:0] wword;
        logic [31:0] waddr;
        int unsigned idx;
        int unsigned acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [MW];
    logic [31:0] last_rdata;
    int unsigned total = 0;
    int unsigned bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] old,
                                  output exp_t e, output logic [31:0] nw);
        logic        legal;
        logic [31:0] b, h, mask;
        int unsigned sh;
        case (f3)
            3'd0:    legal = 1'b1;
            3'd1:    legal = (addr[0] == 1'b0);
            3'd2:    legal = (addr[1:0] == 2'b00);
            3'd4:    legal = !we;
            3'd5:    legal = !we && (addr[0] == 1'b0);
            default: legal = 1'b0;
        endcase
`ifdef LSU_RANGE_CHECK_EN
        if (addr >= 32'(4 * MW)) legal = 1'b0;
`endif
        nw      = old;
        e.err   = !legal;
        e.rdata = '0;
        e.nrd   = 0;
        e.nwr   = 0;
        e.wword = '0;
        e.waddr = {addr[31:2], 2'b00};
        e.idx   = int'(addr[9:2]);
        e.acc   = 0;
        b = (old >> (int'(addr[1:0]) * 8)) & 32'h0000_00FF;
        h = (old >> (addr[1] ? 16 : 0)) & 32'h0000_FFFF;
        if (!legal) begin
            e.lat = 1;
        end else if (!we) begin
            e.lat = 2;
            e.nrd = 1;
            case (f3)
                3'd0:    e.rdata = b[7]  ? (b | 32'hFFFF_FF00) : b;
                3'd1:    e.rdata = h[15] ? (h | 32'hFFFF_0000) : h;
                3'd4:    e.rdata = b;
                3'd5:    e.rdata = h;
                default: e.rdata = old;
            endcase
        end else begin
            e.nwr = 1;
            if (f3 == 3'd2) begin
                e.lat = 2;
                nw    = wdata;
            end else begin
                e.lat = 3;
                e.nrd = 1;
                mask  = (f3 == 3'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
                sh    = (f3 == 3'd0) ? int'(addr[1:0]) * 8 : (addr[1] ? 16 : 0);
                nw    = (old & ~(mask << sh)) | ((wdata & mask) << sh);
            end
            e.wword = nw;
        end
    endfunction

    task automatic wait_resp();
        exp_t        e;
        int unsigned nrd = 0, nwr = 0;
        logic [31:0] wword = '0, maddr = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_read || mem_write) maddr = mem_addr;
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++;
                wword = mem_wdata;
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_resp", 32'd1, 32'd0);
                    return;
                end
                e = sb.pop_front();
                last_rdata = resp_rdata;
                check_eq("resp_err", resp_err, e.err);
                check_eq("resp_rdata", resp_rdata, e.rdata);
                check_eq("latency", cyc - e.acc + 1, e.lat);
                check_eq("n_reads", nrd, e.nrd);
                check_eq("n_writes", nwr, e.nwr);
                check_eq("ready_in_resp", req_ready, 1'b0);
                if (e.nwr != 0) check_eq("mem_wdata", wword, e.wword);
                if (e.nrd + e.nwr != 0) check_eq("mem_addr", maddr, e.waddr);
                check_eq("mem_word", mem[e.idx], ref_mem[e.idx]);
                return;
            end
        end
        check_eq("resp_timeout", 32'd0, 32'd1);
        void'(sb.pop_front());
    endtask

    // Drives one request, pushes the model's prediction on acceptance.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic accepted);
        exp_t        e;
        logic [31:0] nw;
        int unsigned n;
        accepted = 1'b0;
        @(negedge clk);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        for (n = 0; n < 20 && !req_ready; n++) @(negedge clk);
        if (!req_ready) begin
            req_valid = 1'b0;
            check_eq("accept_timeout", 32'd0, 32'd1);
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        model(we, f3, addr, wdata, ref_mem[addr[9:2]], e, nw);
        e.acc = cyc;
        ref_mem[addr[9:2]] = nw;
        sb.push_back(e);
        accepted = 1'b1;
    endtask

    task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata);
        logic ok;
        issue(we, f3, addr, wdata, ok);
        if (ok) wait_resp();
    endtask

    logic [2:0] f3_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    initial begin
        logic        ok;
        logic [31:0] saved;
        int unsigned nwr, nresp;

        reset      = 1'b1;
        clr_mem    = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        last_rdata = '0;
        for (int i = 0; i < int'(MW); i++) ref_mem[i] = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", req_ready, 1'b1);
        check_eq("rst_resp_valid", resp_valid, 1'b0);
        check_eq("rst_resp_err", resp_err, 1'b0);
        check_eq("rst_resp_rdata", resp_rdata, 32'h0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_read", mem_read, 1'b0);
        check_eq("rst_mem_write", mem_write, 1'b0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        reset   = 1'b0;
        clr_mem = 1'b0;

        op(1'b1, 3'd2, 32'h10, 32'h8899_AABB);
        op(1'b0, 3'd0, 32'h13, 32'h0);
        check_eq("lb_0x13", last_rdata, 32'hFFFF_FF88);
        op(1'b0, 3'd4, 32'h13, 32'h0);
        check_eq("lbu_0x13", last_rdata, 32'h0000_0088);
        op(1'b0, 3'd2, 32'h10, 32'h0);
        check_eq("lw_0x10", last_rdata, 32'h8899_AABB);

        op(1'b1, 3'd2, 32'h10, 32'h1122_3344);
        op(1'b1, 3'd0, 32'h11, 32'h0000_00CC);
        check_eq("sb_merged", mem[4], 32'h1122_CC44);
        op(1'b1, 3'd2, 32'h10, 32'h1122_3344);
        op(1'b1, 3'd1, 32'h12, 32'h0000_BEEF);
        check_eq("sh_merged", mem[4], 32'hBEEF_3344);
        op(1'b0, 3'd1, 32'h12, 32'h0);
        check_eq("lh_0x12", last_rdata, 32'hFFFF_BEEF);
        op(1'b0, 3'd5, 32'h12, 32'h0);
        check_eq("lhu_0x12", last_rdata, 32'h0000_BEEF);

        op(1'b0, 3'd2, 32'h22, 32'h0);
        op(1'b1, 3'd1, 32'h21, 32'hFFFF_FFFF);
        op(1'b0, 3'd3, 32'h20, 32'h0);
        op(1'b1, 3'd4, 32'h20, 32'h0);

        // Reset lands in the RMW read cycle: nothing may be written or answered.
        saved = mem[8];
        issue(1'b1, 3'd0, 32'h21, 32'h0000_0077, ok);
        if (ok) begin
            void'(sb.pop_front());
            ref_mem[8] = saved;
            nwr   = 0;
            nresp = 0;
            @(negedge clk);
            reset = 1'b1;
            for (int k = 0; k < 3; k++) begin
                #1;
                if (mem_write) nwr++;
                if (resp_valid) nresp++;
                @(negedge clk);
            end
            reset = 1'b0;
            check_eq("rst_abort_writes", nwr, 0);
            check_eq("rst_abort_resp", nresp, 0);
            check_eq("rst_abort_ready", req_ready, 1'b1);
            check_eq("rst_abort_word", mem[8], saved);
        end

        op(1'b1, 3'd2, 32'h400, 32'hA5A5_5A5A);
        op(1'b0, 3'd2, 32'h0, 32'h0);

        for (int i = 0; i < 16; i++) op(1'b1, 3'd2, 32'(i * 4), $urandom);
        for (int i = 0; i < 60; i++) begin
            op(1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 7)],
               32'($urandom_range(0, 63)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
